// File: rtl/config_reg_bank.sv
// Parametrised configuration register bank with a handshaked write/read channel.
// Supports read-only status registers, self-clearing pulse bits and per-register update strobes.
module config_reg_bank #(
  parameter int                         NUM_REGS     = 8,
  parameter int                         DATA_W       = 32,
  parameter int                         ADDR_W       = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK      = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] PULSE_MASK   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_cmd,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W-1:0]            wr_keep,
  output logic                         wr_ready,
  output logic                         wr_valid,
  output logic [1:0]                   wr_err,
  input  logic                         rd_cmd,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic [1:0]                   rd_err,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          reg_update
);

  typedef enum logic [1:0] {IDLE, EXEC, ACK, RELEASE} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                cap_wr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_data;
  logic [DATA_W-1:0]   cap_keep;
  logic [1:0]          res_err;
  logic [DATA_W-1:0]   rd_stage;

  logic [NUM_REGS-1:0] hit;
  logic                in_range;
  logic                ro_hit;
  logic [1:0]          chk_err;
  logic [DATA_W-1:0]   rd_pick;
  logic [NUM_REGS-1:0] upd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // RELEASE waits for the command that was served to drop, so a held command never runs twice
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wr_ready && (wr_cmd || rd_cmd)) next_state = EXEC;
      EXEC:    next_state = ACK;
      ACK:     next_state = RELEASE;
      RELEASE: if (cap_wr ? !wr_cmd : !rd_cmd) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    hit      = '0;
    in_range = 1'b0;
    rd_pick  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cap_addr == ADDR_W'(i)) begin
        hit[i]   = 1'b1;
        in_range = 1'b1;
        rd_pick  = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i];
      end
    end
    ro_hit  = |(hit & RO_MASK);
    chk_err = !in_range ? 2'b01 : (cap_wr && ro_hit) ? 2'b10 : 2'b00;
    upd_hit = (state == ACK && cap_wr && res_err == 2'b00) ? hit : '0;
  end

  // Pulse bits are cleared on every edge that does not commit a write to that register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_wr     <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      cap_keep   <= '0;
      res_err    <= 2'b00;
      rd_stage   <= '0;
      wr_ready   <= 1'b0;
      wr_valid   <= 1'b0;
      wr_err     <= 2'b00;
      rd_valid   <= 1'b0;
      rd_err     <= 2'b00;
      rd_data    <= '0;
      reg_update <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
    end else begin
      wr_ready   <= (next_state == IDLE);
      wr_valid   <= 1'b0;
      wr_err     <= 2'b00;
      rd_valid   <= 1'b0;
      rd_err     <= 2'b00;
      reg_update <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs[i] & ~PULSE_MASK[i*DATA_W +: DATA_W];
      case (state)
        IDLE: begin
          if (next_state == EXEC) begin
            cap_wr   <= wr_cmd;
            cap_addr <= wr_cmd ? wr_addr : rd_addr;
            cap_data <= wr_data;
            cap_keep <= wr_keep;
          end
        end
        EXEC: begin
          res_err  <= chk_err;
          rd_stage <= in_range ? rd_pick : '0;
        end
        ACK: begin
          if (cap_wr) begin
            wr_valid   <= 1'b1;
            wr_err     <= res_err;
            reg_update <= upd_hit;
            for (int i = 0; i < NUM_REGS; i++)
              if (upd_hit[i]) regs[i] <= (regs[i] & ~cap_keep) | (cap_data & cap_keep);
          end else begin
            rd_valid <= 1'b1;
            rd_err   <= res_err;
            rd_data  <= rd_stage;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? status_in[g*DATA_W +: DATA_W] : regs[g];
  end

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank: directed vector table, corner-case sequences
// and randomized transactions against an array-based reference model.
module tb_config_reg_bank;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam logic [NR*DW-1:0] RST_IMG = 256'd20 << 32;
  localparam logic [NR*DW-1:0] PULSE   = 256'd1 << 192;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_cmd, rd_cmd;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data, wr_keep;
  logic            wr_ready, wr_valid, rd_valid;
  logic [1:0]      wr_err, rd_err;
  logic [DW-1:0]   rd_data;
  logic [NR*DW-1:0] status_in, regs_out;
  logic [NR-1:0]   reg_update;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [NR];

  typedef struct {
    bit          isWr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] keep;
    logic [1:0]  expErr;
    logic [31:0] expRd;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  config_reg_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW),
    .RESET_VALUES(RST_IMG), .RO_MASK(8'h80), .PULSE_MASK(PULSE)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_keep(wr_keep),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_err(wr_err),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .status_in(status_in), .regs_out(regs_out), .reg_update(reg_update)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] modelImage();
    logic [255:0] img;
    for (int i = 0; i < 7; i++) img[i*32 +: 32] = mem[i];
    img[224 +: 32] = status_in[224 +: 32];
    return img;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mem[i] = 32'd0;
    mem[1] = 32'd20;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!wr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("ready wait", 256'(wr_ready), 256'd1);
  endtask

  // Drives one transaction, holding the command 'hold' extra cycles after completion
  task automatic applyStimulus(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                               input logic [31:0] keep, input int hold,
                               output logic [1:0] err, output logic [31:0] rdata,
                               output logic [7:0] upd, output logic [255:0] img,
                               output logic [255:0] img2, output int lat, output int nValid,
                               output logic rdyAtValid);
    waitReady();
    wr_addr = addr; rd_addr = addr; wr_data = data; wr_keep = keep;
    wr_cmd = isWr; rd_cmd = !isWr;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(isWr ? wr_valid : rd_valid) && lat < 20);
    nValid     = int'(wr_valid) + int'(rd_valid);
    err        = isWr ? wr_err : rd_err;
    rdata      = rd_data;
    upd        = reg_update;
    img        = regs_out;
    img2       = '0;
    rdyAtValid = wr_ready;
    if (hold == 0) begin wr_cmd = 1'b0; rd_cmd = 1'b0; end
    for (int k = 0; k < hold + 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) img2 = regs_out;
      nValid += int'(wr_valid) + int'(rd_valid);
      if (k == hold - 1) begin wr_cmd = 1'b0; rd_cmd = 1'b0; end
    end
  endtask

  task automatic runTxn(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [31:0] keep, input int hold,
                        output logic [1:0] err, output logic [31:0] rdata);
    logic [1:0] eErr;
    logic [31:0] eRd;
    logic [7:0] eUpd, upd;
    logic [255:0] eImg, eImg2, img, img2;
    int lat, nValid;
    logic rdy;
    eErr = 2'b00; eRd = '0; eUpd = '0;
    if (addr >= 8'd8) eErr = 2'b01;
    else if (isWr && addr == 8'd7) eErr = 2'b10;
    if (isWr && eErr == 2'b00) begin
      mem[addr[2:0]] = (mem[addr[2:0]] & ~keep) | (data & keep);
      eUpd = 8'd1 << addr[2:0];
    end
    if (!isWr && eErr == 2'b00) eRd = (addr == 8'd7) ? status_in[224 +: 32] : mem[addr[2:0]];
    eImg = modelImage();
    mem[6][0] = 1'b0;
    eImg2 = modelImage();
    applyStimulus(isWr, addr, data, keep, hold, err, rdata, upd, img, img2, lat, nValid, rdy);
    checkOutput("latency", 256'(lat), 256'd3);
    checkOutput("valid count", 256'(nValid), 256'd1);
    checkOutput("ready while busy", 256'(rdy), 256'd0);
    checkOutput(isWr ? "wr_err" : "rd_err", 256'(err), 256'(eErr));
    checkOutput("reg_update", 256'(upd), 256'(isWr ? eUpd : 8'd0));
    checkOutput("image at valid", img, eImg);
    checkOutput("image after valid", img2, eImg2);
    if (!isWr) checkOutput("rd_data", 256'(rdata), 256'(eRd));
  endtask

  initial begin
    logic [1:0] err;
    logic [31:0] rdata;
    int n;

    vecs[0]  = '{1, 8'd2,   32'h12345678, 32'hFFFFFFFF, 2'b00, 32'h0};
    vecs[1]  = '{1, 8'd2,   32'hDEADBEEF, 32'h0000FFFF, 2'b00, 32'h0};
    vecs[2]  = '{0, 8'd2,   32'h0,        32'h0,        2'b00, 32'h1234BEEF};
    vecs[3]  = '{1, 8'd9,   32'h11111111, 32'hFFFFFFFF, 2'b01, 32'h0};
    vecs[4]  = '{0, 8'd9,   32'h0,        32'h0,        2'b01, 32'h0};
    vecs[5]  = '{1, 8'd7,   32'h00000001, 32'hFFFFFFFF, 2'b10, 32'h0};
    vecs[6]  = '{0, 8'd1,   32'h0,        32'h0,        2'b00, 32'h00000014};
    vecs[7]  = '{1, 8'd3,   32'hFFFFFFFF, 32'h00000000, 2'b00, 32'h0};
    vecs[8]  = '{0, 8'd3,   32'h0,        32'h0,        2'b00, 32'h0};
    vecs[9]  = '{1, 8'd255, 32'h22222222, 32'hFFFFFFFF, 2'b01, 32'h0};
    vecs[10] = '{0, 8'd8,   32'h0,        32'h0,        2'b01, 32'h0};
    vecs[11] = '{1, 8'd0,   32'hA5A5A5A5, 32'hF0F0F0F0, 2'b00, 32'h0};
    vecs[12] = '{0, 8'd0,   32'h0,        32'h0,        2'b00, 32'hA0A0A0A0};
    vecs[13] = '{0, 8'd7,   32'h0,        32'h0,        2'b00, 32'hCAFE0007};

    rst = 1'b1; wr_cmd = 1'b0; rd_cmd = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_keep = '0;
    status_in = {32'hCAFE0007, 224'h5A5A_1234_0000_FFFF_DEAD_0000_BEEF_1111_2222_3333_4444_5555_6666_7777};
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset regs_out", regs_out, modelImage());
    checkOutput("reset wr_ready", 256'(wr_ready), 256'd0);
    checkOutput("reset valids", 256'({wr_valid, rd_valid, wr_err, rd_err}), 256'd0);
    checkOutput("reset rd_data/update", 256'({rd_data, reg_update}), 256'd0);
    @(posedge clk); #1;
    checkOutput("ready after release", 256'(wr_ready), 256'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      runTxn(vecs[i].isWr, vecs[i].addr, vecs[i].data, vecs[i].keep, 0, err, rdata);
      checkOutput($sformatf("vec%0d err", i), 256'(err), 256'(vecs[i].expErr));
      if (!vecs[i].isWr) checkOutput($sformatf("vec%0d rd_data", i), 256'(rdata), 256'(vecs[i].expRd));
    end

    $display("[TB] pulse bit sequence");
    runTxn(1'b1, 8'd6, 32'h00000001, 32'hFFFFFFFF, 0, err, rdata);
    runTxn(1'b0, 8'd6, 32'h0, 32'h0, 0, err, rdata);
    checkOutput("pulse readback", 256'(rdata), 256'd0);

    $display("[TB] simultaneous write and read");
    waitReady();
    wr_addr = 8'd2; wr_data = 32'h0BADF00D; wr_keep = 32'hFFFFFFFF; rd_addr = 8'd2;
    wr_cmd = 1'b1; rd_cmd = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wr_valid && !rd_valid && n < 20);
    checkOutput("dual write first", 256'({wr_valid, rd_valid}), 256'b10);
    checkOutput("dual write err", 256'(wr_err), 256'd0);
    mem[2] = 32'h0BADF00D;
    wr_cmd = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rd_valid && n < 20);
    checkOutput("dual read valid", 256'(rd_valid), 256'd1);
    checkOutput("dual read data", 256'(rd_data), 256'h0BADF00D);
    rd_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset during execution");
    waitReady();
    wr_addr = 8'd4; wr_data = 32'hFFFFFFFF; wr_keep = 32'hFFFFFFFF; wr_cmd = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    modelReset();
    checkOutput("mid reset regs", regs_out, modelImage());
    checkOutput("mid reset outs", 256'({wr_ready, wr_valid, rd_valid, reg_update, rd_data}), 256'd0);
    wr_cmd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; n += int'(wr_valid); end
    checkOutput("mid reset no valid", 256'(n), 256'd0);
    checkOutput("mid reset reg4", 256'(regs_out[128 +: 32]), 256'd0);
    checkOutput("mid reset ready", 256'(wr_ready), 256'd1);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 384; i++) begin
      logic [7:0] a;
      logic [31:0] kp;
      status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       kp = 32'hFFFFFFFF;
        1:       kp = 32'h0;
        default: kp = $urandom;
      endcase
      runTxn((i % 3) != 2, a, $urandom, kp, $urandom_range(0, 2), err, rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
